// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage plus the IF/ID pipeline register.
//   Owns the fetch PC, keeps at most one request outstanding to instruction
//   memory, parks one fetched word in a skid buffer when ID stalls, and
//   squashes the wrong-path fetch when ID redirects.
// Ports:
//   i_clk, i_rst_n         clock (rising edge), asynchronous active-low reset
//   i_stall                ID/EX hazard, hold the IF/ID register
//   i_takeBranch, i_jpc    redirect for the instruction currently in o_inst
//   o_memReq, o_memAddr    fetch request / word address (registered)
//   i_memAck, i_memData    request accepted, instruction returned that cycle
//   o_valid, o_pc, o_inst  IF/ID register contents (o_valid=0 is a bubble)
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_takeBranch,
  input  logic [31:0] i_jpc,
  output logic        o_memReq,
  output logic [31:0] o_memAddr,
  input  logic        i_memAck,
  input  logic [31:0] i_memData,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  localparam logic [1:0] ST_FETCH    = 2'd0;
  localparam logic [1:0] ST_BUFFERED = 2'd1;
  localparam logic [1:0] ST_DROP     = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_inst_q, skid_inst_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;

  logic ack_c;
  logic branch_c;

  // Acks only count while a request is actually being presented.
  assign ack_c    = req_q & i_memAck;
  assign branch_c = valid_q & ~i_stall & i_takeBranch;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_FETCH;
      fpc_q       <= RESET_PC;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
      req_q       <= 1'b0;
      addr_q      <= RESET_PC;
      valid_q     <= 1'b0;
      pc_q        <= '0;
      inst_q      <= '0;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
    end
  end

  // Next-state, fetch PC, skid buffer and IF/ID register update.
  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    valid_d     = valid_q;
    pc_d        = pc_q;
    inst_d      = inst_q;

    if (branch_c) begin
      // Redirect: bubble into ID, forget any parked word, restart at target.
      valid_d     = 1'b0;
      inst_d      = '0;
      skid_pc_d   = '0;
      skid_inst_d = '0;
      fpc_d       = i_jpc & WORD_MASK;
      // An unacked request must still complete before the bus is free.
      state_d     = (req_q && !i_memAck) ? ST_DROP : ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (ack_c) begin
            fpc_d = fpc_q + PC_STEP;
            if (!i_stall || !valid_q) begin
              valid_d = 1'b1;
              pc_d    = fpc_q;
              inst_d  = i_memData;
            end else begin
              skid_pc_d   = fpc_q;
              skid_inst_d = i_memData;
              state_d     = ST_BUFFERED;
            end
          end else if (!i_stall) begin
            valid_d = 1'b0;
            inst_d  = '0;
          end
        end
        ST_BUFFERED: begin
          if (!i_stall) begin
            valid_d     = 1'b1;
            pc_d        = skid_pc_q;
            inst_d      = skid_inst_q;
            skid_pc_d   = '0;
            skid_inst_d = '0;
            state_d     = ST_FETCH;
          end
        end
        ST_DROP: begin
          // Wrong-path data is discarded; fpc already holds the target.
          if (ack_c) begin
            state_d = ST_FETCH;
          end
          if (!i_stall) begin
            valid_d = 1'b0;
            inst_d  = '0;
          end
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  // Request side: DROP keeps the squashed address on the bus until acked.
  always_comb begin
    req_d  = (state_d != ST_BUFFERED);
    addr_d = (state_d == ST_DROP) ? addr_q : fpc_d;
  end

  assign o_memReq  = req_q;
  assign o_memAddr = addr_q;
  assign o_valid   = valid_q;
  assign o_pc      = pc_q;
  assign o_inst    = inst_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by random stall/ack/
// redirect traffic. The driver predicts the program-order pc stream ID must
// accept; the monitor pops and compares whenever ID accepts an instruction.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        take;
  logic [31:0] jpc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] inst;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_cur;

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_stall      (stall),
    .i_takeBranch (take),
    .i_jpc        (jpc),
    .o_memReq     (mem_req),
    .o_memAddr    (mem_addr),
    .i_memAck     (mem_ack),
    .i_memData    (mem_data),
    .o_valid      (valid),
    .o_pc         (pc),
    .o_inst       (inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a bijection of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(RST_PC);
    exp_cur = RST_PC;
  endtask

  // One cycle: drive at posedge+2, predict the accepted stream, return at +8.
  task automatic cyc(input logic s, input logic t, input logic [31:0] j, input logic a);
    logic [31:0] nxt;
    @(posedge clk);
    #2;
    stall    = s;
    take     = t;
    jpc      = j;
    mem_ack  = a;
    mem_data = (a && mem_req) ? mem_fn(mem_addr) : $urandom;
    if (rst_n && valid && !s) begin
      nxt = t ? (j & 32'hFFFF_FFFC) : exp_cur + 32'd4;
      exp_q.push_back(nxt);
      exp_cur = nxt;
    end
    #6;
  endtask

  // Monitor: scoreboard on every accepted instruction plus protocol checks.
  initial begin
    logic        h_ok, p_req, p_ack, p_valid, p_stall;
    logic [31:0] p_addr, p_pc, p_inst, e;
    int          idle;
    h_ok = 1'b0; p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0; p_stall = 1'b0;
    p_addr = '0; p_pc = '0; p_inst = '0; idle = 0;
    forever begin
      @(posedge clk);
      #8;
      if (!rst_n) begin
        h_ok = 1'b0;
        idle = 0;
      end else begin
        if (valid && !stall) begin
          idle = 0;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_extra: got pc %h with no expected entry", pc);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", pc, e);
            chk("sb_inst", inst, mem_fn(e));
          end
        end else begin
          idle++;
          if (idle >= 200) begin
            checks++; errors++;
            $display("FAIL watchdog: got %0d idle cycles expected < 200", idle);
            idle = 0;
          end
        end
        if (mem_req) chk("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
        if (h_ok && p_req && !p_ack) begin
          chk("req_hold", {31'd0, mem_req}, 32'd1);
          chk("addr_hold", mem_addr, p_addr);
        end
        if (h_ok && p_valid && p_stall) begin
          chk("stall_valid", {31'd0, valid}, 32'd1);
          chk("stall_pc", pc, p_pc);
          chk("stall_inst", inst, p_inst);
        end
        h_ok = 1'b1;
        p_req = mem_req; p_ack = mem_ack; p_addr = mem_addr;
        p_valid = valid; p_stall = stall; p_pc = pc; p_inst = inst;
      end
    end
  end

  initial begin
    logic        s, t, a;
    logic [31:0] j;
    rst_n = 1'b0; stall = 1'b0; take = 1'b0; jpc = '0; mem_ack = 1'b0; mem_data = '0;
    model_reset();

    // Reset values.
    cyc(0, 0, 0, 1);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, RST_PC);
    rst_n = 1'b1;

    // Back-to-back acks: one instruction per cycle.
    cyc(0, 0, 0, 1);
    chk("first_req", {31'd0, mem_req}, 32'd1);
    chk("addr0", mem_addr, 32'h0);
    cyc(0, 0, 0, 1);
    chk("addr4", mem_addr, 32'h4);
    chk("pc0", pc, 32'h0);
    chk("valid0", {31'd0, valid}, 32'd1);
    // Stall three cycles while 0x8 is acked.
    cyc(1, 0, 0, 1);
    chk("addr8", mem_addr, 32'h8);
    chk("pc4", pc, 32'h4);
    cyc(1, 0, 0, 0);
    chk("buf_req0", {31'd0, mem_req}, 32'd0);
    chk("buf_pc_a", pc, 32'h4);
    cyc(1, 0, 0, 0);
    chk("buf_req1", {31'd0, mem_req}, 32'd0);
    cyc(0, 0, 0, 0);
    chk("buf_pc_b", pc, 32'h4);
    cyc(0, 0, 0, 1);
    chk("unbuf_pc8", pc, 32'h8);
    chk("addrC", mem_addr, 32'hC);
    cyc(0, 0, 0, 1);
    chk("pcC", pc, 32'hC);
    // Branch with same-edge ack of the wrong-path word.
    cyc(0, 1, 32'h40, 1);
    chk("pc10", pc, 32'h10);
    chk("addr14", mem_addr, 32'h14);
    cyc(0, 0, 0, 1);
    chk("br_bubble", {31'd0, valid}, 32'd0);
    chk("br_nop", inst, 32'd0);
    chk("br_addr40", mem_addr, 32'h40);
    // Branch with the wrong-path ack delayed three cycles.
    cyc(0, 1, 32'h80, 0);
    chk("pc40", pc, 32'h40);
    chk("addr44", mem_addr, 32'h44);
    cyc(0, 0, 0, 0);
    chk("drop_addr_a", mem_addr, 32'h44);
    cyc(0, 0, 0, 0);
    chk("drop_req", {31'd0, mem_req}, 32'd1);
    cyc(0, 0, 0, 1);
    chk("drop_addr_b", mem_addr, 32'h44);
    cyc(0, 0, 0, 1);
    chk("addr80", mem_addr, 32'h80);
    // Branch requested under stall is ignored until the unstalled edge.
    cyc(1, 1, 32'h43, 1);
    chk("pc80", pc, 32'h80);
    cyc(1, 1, 32'h43, 0);
    chk("stbr_pc", pc, 32'h80);
    cyc(0, 1, 32'h43, 0);
    chk("stbr_req", {31'd0, mem_req}, 32'd0);
    cyc(0, 0, 0, 1);
    chk("stbr_addr40", mem_addr, 32'h40);
    cyc(0, 1, 32'hFFFF_FFFC, 1);
    chk("stbr_pc40", pc, 32'h40);
    // Wrap of the fetch PC.
    cyc(0, 0, 0, 1);
    chk("addr_top", mem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    chk("wrap_addr", mem_addr, 32'h0);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);

    // Asynchronous reset while a request waits for its ack.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_addr", mem_addr, RST_PC);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    rst_n = 1'b1;
    cyc(0, 0, 0, 1);
    chk("rrst_req", {31'd0, mem_req}, 32'd1);
    chk("rrst_addr", mem_addr, RST_PC);
    cyc(0, 0, 0, 1);
    chk("rrst_pc", pc, RST_PC);
    chk("rrst_inst", inst, mem_fn(RST_PC));

    // Random traffic, including spurious acks and wrap-around targets.
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom % 100) < 25;
      a = ($urandom % 100) < 60;
      t = ($urandom % 100) < 20;
      case ($urandom % 4)
        0:       j = $urandom % 256;
        1:       j = 32'hFFFF_FFF0 | ($urandom % 16);
        default: j = $urandom;
      endcase
      cyc(s, t, j, a);
    end
    cyc(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
